fp_add_seq: RTL

//  Multi-cycle IEEE-754 double-precision adder/subtractor controller with valid/ready handshake.

---
 rtl/fp_add_seq_pkg.sv | 52 +++++
 rtl/fp_add_seq_if.sv | 31 +++
 rtl/fp_add_seq_addsub.sv | 24 ++
 rtl/fp_add_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_seq_pkg.sv
// ---------------------------------------------------------------------------
// fp_add_seq_pkg
// Shared definitions for the sequential double-precision adder/subtractor:
// FSM state encoding, field widths, special encodings and helpers that
// classify IEEE-754 doubles and build the Inf/NaN result.
// ---------------------------------------------------------------------------
package fp_add_seq_pkg;

   localparam int DW    = 64;   // IEEE double width
   localparam int EXP_W = 11;   // exponent width, matches the addsub unit
   localparam int MAN_W = 52;   // stored fraction width
   localparam int WM    = 54;   // working mantissa {carry, hidden, frac}

   localparam logic [EXP_W-1:0] EXP_MAX = 11'h7FF;
   localparam logic [DW-1:0]    QNAN    = 64'h7FF8_0000_0000_0000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DIFF  = 3'd1,
      ALIGN = 3'd2,
      ADD   = 3'd3,
      NORM  = 3'd4,
      PACK  = 3'd5,
      DONE  = 3'd6
   } state_t;

   function automatic logic is_nan(input logic [DW-1:0] x);
      return (x[62:52] == EXP_MAX) && (x[MAN_W-1:0] != 52'd0);
   endfunction

   function automatic logic is_inf(input logic [DW-1:0] x);
      return (x[62:52] == EXP_MAX) && (x[MAN_W-1:0] == 52'd0);
   endfunction

   // Result when at least one operand has the all-ones exponent.
   // b must already carry its effective sign (op applied).
   function automatic logic [DW-1:0] special_result(input logic [DW-1:0] a,
                                                    input logic [DW-1:0] b);
      logic [DW-1:0] r;
      if (is_nan(a) || is_nan(b)) begin
         r = QNAN;
      end else if (is_inf(a) && is_inf(b) && (a[63] != b[63])) begin
         r = QNAN;
      end else if (is_inf(a)) begin
         r = a;
      end else begin
         r = b;
      end
      return r;
   endfunction

endpackage

// File: rtl/fp_add_seq_if.sv
// ---------------------------------------------------------------------------
// fp_add_seq_if
// Operand/result handshake bundle for fp_add_seq.
//   in_valid/in_ready/in_a/in_b/in_op : operand pair from the source
//   out_valid/out_ready/out_result    : result towards the consumer
//   busy                              : adder is working on an operation
// master = source/consumer side, slave = the adder.
// ---------------------------------------------------------------------------
interface fp_add_seq_if;
   import fp_add_seq_pkg::*;

   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_a;
   logic [DW-1:0] in_b;
   logic          in_op;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_result;
   logic          busy;

   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, out_result, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, out_result, busy
   );
endinterface

// File: rtl/fp_add_seq_addsub.sv
// ---------------------------------------------------------------------------
// fp_add_seq_addsub
// Shared 11-bit exponent add/subtract unit.
//   dataa, datab : 11-bit operands
//   add_sub      : 1 = dataa + datab, 0 = dataa - datab
//   answer       : low 11 bits of the result
//   sign12       : bit 11 of the 12-bit result (borrow when subtracting)
// ---------------------------------------------------------------------------
module fp_add_seq_addsub
   import fp_add_seq_pkg::*;
(
   input  logic [EXP_W-1:0] dataa,
   input  logic [EXP_W-1:0] datab,
   input  logic             add_sub,
   output logic [EXP_W-1:0] answer,
   output logic             sign12
);
   logic [EXP_W:0] result;

   assign result = add_sub ? ({1'b0, dataa} + {1'b0, datab})
                           : ({1'b0, dataa} - {1'b0, datab});
   assign answer = result[EXP_W-1:0];
   assign sign12 = result[EXP_W];
endmodule

// File: rtl/fp_add_seq.sv
// ---------------------------------------------------------------------------
// fp_add_seq
// Multi-cycle IEEE-754 double add/subtract, truncating, denormals flushed.
// One shared exponent addsub is reused for the exponent difference and for
// the +1/-1 steps of normalisation.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : fp_add_seq_if.slave (operand handshake, result handshake, busy)
// ---------------------------------------------------------------------------
module fp_add_seq
   import fp_add_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   fp_add_seq_if.slave bus
);
   state_t            state_r, state_n;
   logic [DW-1:0]     a_r, a_n, b_r, b_n;      // latched operands, b with effective sign
   logic [DW-1:0]     l_r, l_n, s_r, s_n;      // larger / smaller exponent operand
   logic [EXP_W-1:0]  exp_r, exp_n, shamt_r, shamt_n;
   logic [WM-1:0]     m_r, m_n, ms_r, ms_n;
   logic              sign_r, sign_n;
   logic [DW-1:0]     result_r, result_n;
   logic              out_valid_r, out_valid_n;
   logic              in_ready_r, busy_r;

   logic [EXP_W-1:0]  as_a, as_b, as_ans;
   logic              as_add, as_sign;
   logic [WM-1:0]     l_man, s_man, s_shift, add_m;
   logic              add_sign;
   logic [DW-1:0]     special;

   fp_add_seq_addsub u_exp (
      .dataa   (as_a),
      .datab   (as_b),
      .add_sub (as_add),
      .answer  (as_ans),
      .sign12  (as_sign)
   );

   // Exponent unit input mux: only DIFF and NORM use it, zero elsewhere
   always_comb begin
      as_a   = {EXP_W{1'b0}};
      as_b   = {EXP_W{1'b0}};
      as_add = 1'b0;
      case (state_r)
         DIFF: begin
            as_a   = a_r[62:52];
            as_b   = b_r[62:52];
            as_add = 1'b0;
         end
         NORM: begin
            as_a   = exp_r;
            as_b   = 11'd1;
            as_add = m_r[WM-1];     // carry set -> increment, else decrement
         end
         default: begin
            as_a   = {EXP_W{1'b0}};
         end
      endcase
   end

   // Datapath helpers: working mantissas, alignment shift, magnitude add/sub
   always_comb begin
      l_man   = (l_r[62:52] != 11'd0) ? {2'b01, l_r[MAN_W-1:0]} : {WM{1'b0}};
      s_man   = (s_r[62:52] != 11'd0) ? {2'b01, s_r[MAN_W-1:0]} : {WM{1'b0}};
      special = special_result(a_r, b_r);
      if (shamt_r >= 11'd54) begin
         s_shift = {WM{1'b0}};
      end else begin
         s_shift = s_man >> shamt_r;
      end
      if (l_r[63] == s_r[63]) begin
         add_m    = m_r + ms_r;
         add_sign = l_r[63];
      end else if (m_r >= ms_r) begin
         add_m    = m_r - ms_r;
         add_sign = l_r[63];
      end else begin
         add_m    = ms_r - m_r;
         add_sign = s_r[63];
      end
   end

   // FSM next state and datapath next values
   always_comb begin
      state_n     = state_r;
      a_n         = a_r;
      b_n         = b_r;
      l_n         = l_r;
      s_n         = s_r;
      exp_n       = exp_r;
      shamt_n     = shamt_r;
      m_n         = m_r;
      ms_n        = ms_r;
      sign_n      = sign_r;
      result_n    = result_r;
      out_valid_n = out_valid_r;
      case (state_r)
         IDLE: begin
            if (bus.in_valid) begin
               a_n     = bus.in_a;
               b_n     = {bus.in_b[63] ^ bus.in_op, bus.in_b[62:0]};
               state_n = DIFF;
            end else begin
               state_n = IDLE;
            end
         end
         DIFF: begin
            // A borrow means expB > expA: swap and negate the difference
            if (as_sign) begin
               l_n     = b_r;
               s_n     = a_r;
               exp_n   = b_r[62:52];
               shamt_n = 11'd0 - as_ans;
            end else begin
               l_n     = a_r;
               s_n     = b_r;
               exp_n   = a_r[62:52];
               shamt_n = as_ans;
            end
            if ((a_r[62:52] == EXP_MAX) || (b_r[62:52] == EXP_MAX)) begin
               sign_n  = special[63];
               exp_n   = special[62:52];
               m_n     = {2'b00, special[MAN_W-1:0]};
               state_n = PACK;
            end else begin
               state_n = ALIGN;
            end
         end
         ALIGN: begin
            m_n     = l_man;
            ms_n    = s_shift;
            state_n = ADD;
         end
         ADD: begin
            if (add_m == {WM{1'b0}}) begin
               sign_n  = 1'b0;
               exp_n   = {EXP_W{1'b0}};
               m_n     = {WM{1'b0}};
               state_n = PACK;
            end else begin
               sign_n  = add_sign;
               m_n     = add_m;
               state_n = NORM;
            end
         end
         NORM: begin
            if (m_r[WM-1]) begin
               if (as_ans == EXP_MAX) begin
                  exp_n   = EXP_MAX;            // overflow to signed Inf
                  m_n     = {WM{1'b0}};
                  state_n = PACK;
               end else begin
                  exp_n   = as_ans;
                  m_n     = m_r >> 1;
               end
            end else if (!m_r[WM-2]) begin
               if (as_ans == {EXP_W{1'b0}}) begin
                  exp_n   = {EXP_W{1'b0}};      // would go denormal: signed zero
                  m_n     = {WM{1'b0}};
                  state_n = PACK;
               end else begin
                  exp_n   = as_ans;
                  m_n     = m_r << 1;
               end
            end else begin
               state_n = PACK;
            end
         end
         PACK: begin
            result_n    = {sign_r, exp_r, m_r[MAN_W-1:0]};
            out_valid_n = 1'b1;
            state_n     = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_n = 1'b0;
               state_n     = IDLE;
            end else begin
               out_valid_n = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State and datapath registers; handshake flags registered from next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         a_r         <= {DW{1'b0}};
         b_r         <= {DW{1'b0}};
         l_r         <= {DW{1'b0}};
         s_r         <= {DW{1'b0}};
         exp_r       <= {EXP_W{1'b0}};
         shamt_r     <= {EXP_W{1'b0}};
         m_r         <= {WM{1'b0}};
         ms_r        <= {WM{1'b0}};
         sign_r      <= 1'b0;
         result_r    <= {DW{1'b0}};
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_n;
         a_r         <= a_n;
         b_r         <= b_n;
         l_r         <= l_n;
         s_r         <= s_n;
         exp_r       <= exp_n;
         shamt_r     <= shamt_n;
         m_r         <= m_n;
         ms_r        <= ms_n;
         sign_r      <= sign_n;
         result_r    <= result_n;
         out_valid_r <= out_valid_n;
         in_ready_r  <= (state_n == IDLE);
         busy_r      <= (state_n != IDLE);
      end
   end

   assign bus.in_ready   = in_ready_r;
   assign bus.busy       = busy_r;
   assign bus.out_valid  = out_valid_r;
   assign bus.out_result = result_r;
endmodule
